// File: rtl/channel_lut_pkg.sv
// Shared types and constants for the channel-selector LUT configuration controller.
package channel_lut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_GAP      = 2'd2,
        ST_CTRL_ACK = 2'd3
    } lut_state_e;

    localparam logic [1:0] LUT_IDLE = 2'b00;
    localparam logic [1:0] LUT_WR   = 2'b10;
    localparam logic [1:0] LUT_RD   = 2'b01;

    localparam int CTRL_INIT_BIT = 0;
    localparam int CTRL_CLR_BIT  = 1;

    // Identity map: rising channel a (1..2**outp_w) selects virtual channel a-1 with valid set.
    function automatic logic [31:0] default_entry(input logic [31:0] addr, input int outp_w);
        logic [31:0] span;
        span = 32'd1 << outp_w;
        if ((addr >= 32'd1) && (addr <= span)) begin
            return span | (addr - 32'd1);
        end else begin
            return 32'd0;
        end
    endfunction

endpackage

// File: rtl/channel_lut_ctrl_if.sv
// Wishbone host bus between the configuration host and the LUT controller.
interface channel_lut_ctrl_if #(
    parameter int ADR_W = 7
);
    logic             wb_cyc;
    logic             wb_stb;
    logic             wb_we;
    logic [ADR_W-1:0] wb_adr;
    logic [31:0]      wb_dat_i;
    logic [31:0]      wb_dat_o;
    logic             wb_ack;

    modport master (output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i, input wb_dat_o, wb_ack);
    modport slave  (input wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i, output wb_dat_o, wb_ack);
endinterface

// File: rtl/channel_lut_ctrl.sv
// Sole master of the LUT request/ack port: arbitrates the Wishbone host against the
// identity-map init sequencer, with a timeout guarding every LUT operation.
module channel_lut_ctrl
    import channel_lut_pkg::*;
#(
    parameter int CHANNEL_INP_WIDTH  = 6,
    parameter int CHANNEL_OUTP_WIDTH = 4,
    parameter bit AUTO_INIT          = 1'b1,
    parameter int TIMEOUT_CYCLES     = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    channel_lut_ctrl_if.slave             wb,
    input  logic                          reset_comb_done,
    output logic [1:0]                    lut_WrRd,
    output logic [CHANNEL_INP_WIDTH-1:0]  lut_addr,
    output logic [CHANNEL_OUTP_WIDTH:0]   lut_dat_o,
    input  logic [CHANNEL_OUTP_WIDTH:0]   lut_dat_i,
    input  logic                          lut_ack,
    output logic                          init_busy
);
    localparam int IW            = CHANNEL_INP_WIDTH;
    localparam int OW            = CHANNEL_OUTP_WIDTH;
    localparam int CTRL_ADDR_BIT = CHANNEL_INP_WIDTH;
    localparam int TW            = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] MAX_ADDR = {IW{1'b1}};
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    lut_state_e  state_q, state_d;
    logic        init_req_q, init_req_d;
    logic        init_busy_q, init_busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        host_drop_q, host_drop_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [1:0]  lut_wrrd_q, lut_wrrd_d;
    logic [IW-1:0] lut_addr_q, lut_addr_d;
    logic [OW:0] lut_dat_q, lut_dat_d;
    logic        wb_ack_q, wb_ack_d;
    logic [31:0] wb_dat_q, wb_dat_d;

    logic          host_req_s, init_start_s, ctrl_take_s, host_lut_take_s, last_s, tmo_s;
    logic [IW-1:0] nxt_addr_s;
    logic [31:0]   ent_nxt_s, ent_zero_s;
    logic          unused_s;

    assign host_req_s   = wb.wb_cyc && wb.wb_stb;
    assign init_start_s = init_req_q || (AUTO_INIT && reset_comb_done);
    assign last_s       = (lut_addr_q == MAX_ADDR);
    assign tmo_s        = (tmo_cnt_q == TMO_LAST);
    assign nxt_addr_s   = lut_addr_q + IW'(1);
    assign ent_nxt_s    = default_entry(32'(nxt_addr_s), OW);
    assign ent_zero_s   = default_entry(32'd0, OW);
    assign unused_s     = ^wb.wb_dat_i[31:OW+1];

    // Control accesses are served from IDLE, and from GAP so busy can be polled mid-init.
    assign ctrl_take_s = host_req_s && wb.wb_adr[CTRL_ADDR_BIT] &&
                         (((state_q == ST_IDLE) && !init_start_s) ||
                          ((state_q == ST_GAP) && init_busy_q));
    assign host_lut_take_s = host_req_s && !wb.wb_adr[CTRL_ADDR_BIT] &&
                             (state_q == ST_IDLE) && !init_start_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (init_start_s || host_lut_take_s) state_d = ST_REQ;
                else if (ctrl_take_s)                state_d = ST_CTRL_ACK;
                else                                 state_d = ST_IDLE;
            end
            ST_REQ: begin
                if (lut_ack || tmo_s) state_d = ST_GAP;
                else                  state_d = ST_REQ;
            end
            ST_GAP: begin
                if (ctrl_take_s)                 state_d = ST_CTRL_ACK;
                else if (init_busy_q && !last_s) state_d = ST_REQ;
                else                             state_d = ST_IDLE;
            end
            ST_CTRL_ACK: state_d = init_busy_q ? ST_GAP : ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        init_req_d  = init_req_q;
        init_busy_d = init_busy_q;
        done_d      = done_q;
        err_d       = err_q;
        host_drop_d = host_drop_q;
        tmo_cnt_d   = tmo_cnt_q;
        lut_wrrd_d  = lut_wrrd_q;
        lut_addr_d  = lut_addr_q;
        lut_dat_d   = lut_dat_q;
        wb_ack_d    = 1'b0;
        wb_dat_d    = 32'd0;

        if (AUTO_INIT && reset_comb_done && !init_busy_q) init_req_d = 1'b1;
        else                                              init_req_d = init_req_q;

        if (ctrl_take_s) begin
            wb_ack_d = 1'b1;
            if (wb.wb_we) begin
                if (wb.wb_dat_i[CTRL_INIT_BIT] && !init_busy_q) init_req_d = 1'b1;
                else                                            init_req_d = init_req_d;
                if (wb.wb_dat_i[CTRL_CLR_BIT]) begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                end else begin
                    done_d = done_q;
                end
            end else begin
                wb_dat_d = {29'd0, err_q, done_q, init_busy_q};
            end
        end else begin
            wb_dat_d = 32'd0;
        end

        case (state_q)
            ST_IDLE: begin
                if (init_start_s) begin
                    init_req_d  = 1'b0;
                    init_busy_d = 1'b1;
                    lut_addr_d  = '0;
                    lut_dat_d   = ent_zero_s[OW:0];
                    lut_wrrd_d  = LUT_WR;
                    tmo_cnt_d   = '0;
                end else if (host_lut_take_s) begin
                    lut_addr_d  = wb.wb_adr[IW-1:0];
                    lut_dat_d   = wb.wb_dat_i[OW:0];
                    lut_wrrd_d  = wb.wb_we ? LUT_WR : LUT_RD;
                    tmo_cnt_d   = '0;
                    host_drop_d = 1'b0;
                end else begin
                    lut_wrrd_d  = LUT_IDLE;
                end
            end
            ST_REQ: begin
                if (!wb.wb_cyc) host_drop_d = 1'b1;
                else            host_drop_d = host_drop_q;
                if (lut_ack || tmo_s) begin
                    lut_wrrd_d = LUT_IDLE;
                    if (!lut_ack) err_d = 1'b1;
                    else          err_d = err_q;
                    // A host that abandoned the cycle gets no acknowledge.
                    if (!init_busy_q && wb.wb_cyc && !host_drop_q) begin
                        wb_ack_d = 1'b1;
                        wb_dat_d = (lut_ack && (lut_wrrd_q == LUT_RD)) ? 32'(lut_dat_i) : 32'd0;
                    end else begin
                        wb_ack_d = 1'b0;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            ST_GAP: begin
                if (!ctrl_take_s && init_busy_q) begin
                    if (!last_s) begin
                        lut_addr_d = nxt_addr_s;
                        lut_dat_d  = ent_nxt_s[OW:0];
                        lut_wrrd_d = LUT_WR;
                        tmo_cnt_d  = '0;
                    end else begin
                        init_busy_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end else begin
                    lut_wrrd_d = LUT_IDLE;
                end
            end
            ST_CTRL_ACK: lut_wrrd_d = LUT_IDLE;
            default:     lut_wrrd_d = LUT_IDLE;
        endcase
    end

    // Registered outputs and sticky status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_req_q  <= 1'b0;
            init_busy_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            host_drop_q <= 1'b0;
            tmo_cnt_q   <= '0;
            lut_wrrd_q  <= LUT_IDLE;
            lut_addr_q  <= '0;
            lut_dat_q   <= '0;
            wb_ack_q    <= 1'b0;
            wb_dat_q    <= 32'd0;
        end else begin
            init_req_q  <= init_req_d;
            init_busy_q <= init_busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            host_drop_q <= host_drop_d;
            tmo_cnt_q   <= tmo_cnt_d;
            lut_wrrd_q  <= lut_wrrd_d;
            lut_addr_q  <= lut_addr_d;
            lut_dat_q   <= lut_dat_d;
            wb_ack_q    <= wb_ack_d;
            wb_dat_q    <= wb_dat_d;
        end
    end

    assign lut_WrRd    = lut_wrrd_q;
    assign lut_addr    = lut_addr_q;
    assign lut_dat_o   = lut_dat_q;
    assign init_busy   = init_busy_q;
    assign wb.wb_ack   = wb_ack_q;
    assign wb.wb_dat_o = wb_dat_q;

endmodule
